// File: rtl/adc_spi_responder.sv
// Slave-side loop-back model of an 8-channel 12-bit serial ADC, clocked entirely by clk_50.
// Define ADC_FRAME_ERR_EN to add the frame_err / err_count abort reporting ports.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        adc_cs_n,
  input  logic        adc_sck,
  input  logic        din,
  input  logic [95:0] chan_data,
  output logic        dout,
  output logic        frame_done,
  output logic [2:0]  frame_addr,
  output logic [2:0]  next_addr
`ifdef ADC_FRAME_ERR_EN
  ,
  output logic        frame_err,
  output logic [7:0]  err_count
`endif
);

  localparam int DATA_W = 12;
  localparam int CNT_W  = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  localparam logic [1:0] WAIT_HIGH = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  function automatic logic [DATA_W-1:0] chan_sel(input logic [95:0] d, input logic [2:0] a);
    return d[a*DATA_W +: DATA_W];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] cs_sync_p0;
  logic [SYNC_STAGES-1:0] sck_sync_p0;
  logic [SYNC_STAGES-1:0] din_sync_p0;
  logic                   cs_prev_p1;
  logic                   sck_prev_p1;

  logic                   cs_s, sck_s, din_s;
  logic                   cs_fall, cs_rise, sck_fall, sck_rise;

  logic [1:0]             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [2:0]             addr_cap;
  logic                   reload_pend;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [FRAME_BITS-1:0]  load_word;

  // Stage p0: synchronizers; din is delayed identically so it stays aligned with sck
  always_ff @(posedge clk_50) begin
    if (rst) begin
      cs_sync_p0  <= '1;
      sck_sync_p0 <= '1;
    end else begin
      cs_sync_p0  <= {cs_sync_p0[SYNC_STAGES-2:0], adc_cs_n};
      sck_sync_p0 <= {sck_sync_p0[SYNC_STAGES-2:0], adc_sck};
    end
  end

  always_ff @(posedge clk_50) begin
    din_sync_p0 <= {din_sync_p0[SYNC_STAGES-2:0], din};
  end

  assign cs_s  = cs_sync_p0[SYNC_STAGES-1];
  assign sck_s = sck_sync_p0[SYNC_STAGES-1];
  assign din_s = din_sync_p0[SYNC_STAGES-1];

  // Stage p1: edge detection on synchronized copies
  always_ff @(posedge clk_50) begin
    if (rst) begin
      cs_prev_p1  <= 1'b1;
      sck_prev_p1 <= 1'b1;
    end else begin
      cs_prev_p1  <= cs_s;
      sck_prev_p1 <= sck_s;
    end
  end

  assign cs_fall  = cs_prev_p1 & ~cs_s;
  assign cs_rise  = ~cs_prev_p1 & cs_s;
  assign sck_fall = sck_prev_p1 & ~sck_s;
  assign sck_rise = ~sck_prev_p1 & sck_s;

  assign load_word = FRAME_BITS'(chan_sel(chan_data, next_addr));

  // Stage p2: frame control; a cs_n rise always takes priority over a same-cycle sck edge
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state       <= WAIT_HIGH;
      bit_cnt     <= '0;
      addr_cap    <= 3'd0;
      reload_pend <= 1'b0;
      frame_done  <= 1'b0;
      frame_addr  <= 3'd0;
      next_addr   <= 3'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        WAIT_HIGH: begin
          if (cs_s) state <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
          end else if (sck_rise) begin
            if (bit_cnt == CNT_W'(2)) addr_cap[2] <= din_s;
            if (bit_cnt == CNT_W'(3)) addr_cap[1] <= din_s;
            if (bit_cnt == CNT_W'(4)) addr_cap[0] <= din_s;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt     <= '0;
              frame_done  <= 1'b1;
              frame_addr  <= next_addr;
              next_addr   <= addr_cap;
              reload_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sck_fall) begin
            reload_pend <= 1'b0;
          end
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end

  // After a completed frame the next sck fall starts the following frame instead of shifting
  always_ff @(posedge clk_50) begin
    if (state == IDLE && cs_fall) begin
      shift_reg <= load_word;
    end else if (state == ACTIVE && !cs_rise && sck_fall) begin
      shift_reg <= reload_pend ? load_word : {shift_reg[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign dout = (state == ACTIVE) & shift_reg[FRAME_BITS-1];

`ifdef ADC_FRAME_ERR_EN
  always_ff @(posedge clk_50) begin
    if (rst) begin
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      frame_err <= 1'b0;
      if (state == ACTIVE && cs_rise && bit_cnt != '0) begin
        frame_err <= 1'b1;
        err_count <= sat_inc(err_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench: a behavioural SPI master drives frames; expected words are queued per frame.
module tb_adc_spi_responder;

  localparam int H = 6;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        adc_cs_n;
  logic        adc_sck;
  logic        din;
  logic [95:0] chan_data;
  logic        dout;
  logic        frame_done;
  logic [2:0]  frame_addr;
  logic [2:0]  next_addr;
`ifdef ADC_FRAME_ERR_EN
  logic        frame_err;
  logic [7:0]  err_count;
  int          err_pulses = 0;
`endif

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [11:0] ch_m [8];
  logic [15:0] exp_q [$];
  logic [2:0]  m_next, m_frame;

  always #10 clk_50 = ~clk_50;

  adc_spi_responder dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .adc_cs_n   (adc_cs_n),
    .adc_sck    (adc_sck),
    .din        (din),
    .chan_data  (chan_data),
    .dout       (dout),
    .frame_done (frame_done),
    .frame_addr (frame_addr),
    .next_addr  (next_addr)
`ifdef ADC_FRAME_ERR_EN
    ,
    .frame_err  (frame_err),
    .err_count  (err_count)
`endif
  );

  always @(negedge clk_50) if (frame_done === 1'b1) done_cnt++;
`ifdef ADC_FRAME_ERR_EN
  always @(negedge clk_50) if (frame_err === 1'b1) err_pulses++;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_ch();
    for (int k = 0; k < 8; k++) chan_data[12*k +: 12] = ch_m[k];
  endtask

  function automatic logic dbit(input logic [2:0] a, input int i);
    case (i)
      2: return a[2];
      3: return a[1];
      4: return a[0];
      default: return 1'b0;
    endcase
  endfunction

  // One sck period: fall (din changes), hold, sample dout just before the rise, rise, hold.
  task automatic clock_bit(input logic d, output logic q);
    adc_sck = 1'b0;
    din     = d;
    repeat (H) @(negedge clk_50);
    q = dout;
    adc_sck = 1'b1;
    repeat (H) @(negedge clk_50);
  endtask

  task automatic run_frame(input logic [2:0] a, input int nbits, input bit start,
                           output logic [15:0] word);
    logic q;
    word = '0;
    if (start) adc_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      clock_bit(dbit(a, i), q);
      word = {word[14:0], q};
    end
  endtask

  task automatic full_frame(input string tag, input logic [2:0] a, input bit start);
    logic [15:0] w;
    int d0;
    exp_q.push_back({4'b0000, ch_m[m_next]});
    d0 = done_cnt;
    run_frame(a, 16, start, w);
    check({tag, "_data"}, 32'(w), 32'(exp_q.pop_front()));
    check({tag, "_done"}, done_cnt - d0, 1);
    m_frame = m_next;
    m_next  = a;
    check({tag, "_frame_addr"}, 32'(frame_addr), 32'(m_frame));
    check({tag, "_next_addr"}, 32'(next_addr), 32'(m_next));
  endtask

  task automatic end_frame();
    adc_cs_n = 1'b1;
    repeat (H) @(negedge clk_50);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_50);
    rst = 1'b0;
    m_next  = 3'd0;
    m_frame = 3'd0;
    repeat (5) @(negedge clk_50);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w, e;
    int d0;
    rst = 1'b1; adc_cs_n = 1'b1; adc_sck = 1'b1; din = 1'b0;
    for (int k = 0; k < 8; k++) ch_m[k] = 12'h000;
    ch_m[0] = 12'hA5C;
    pack_ch();
    m_next = 3'd0; m_frame = 3'd0;
    repeat (4) @(negedge clk_50);
    check("rst_dout", 32'(dout), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_addr", 32'(frame_addr), 0);
    check("rst_next_addr", 32'(next_addr), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk_50);

    // Single frames
    full_frame("s1", 3'd5, 1'b1);
    end_frame();
    ch_m[5] = 12'h3F1; pack_ch();
    full_frame("s2", 3'd2, 1'b1);
    end_frame();

    // Back-to-back frames with cs_n held low
    do_reset();
    ch_m[0] = 12'h001; ch_m[7] = 12'hFFF; pack_ch();
    d0 = done_cnt;
    full_frame("s3a", 3'd7, 1'b1);
    full_frame("s3b", 3'd1, 1'b0);
    end_frame();
    check("s3_two_done", done_cnt - d0, 2);

    // Abort after 9 rises
    ch_m[1] = 12'h2B7; pack_ch();
    d0 = done_cnt;
    run_frame(3'd3, 9, 1'b1, w);
    end_frame();
    e = {4'b0000, ch_m[1]};
    check("s4_partial", 32'(w[8:0]), 32'(e[15:7]));
    check("s4_dout_idle", 32'(dout), 0);
    check("s4_no_done", done_cnt - d0, 0);
    check("s4_next_addr", 32'(next_addr), 32'(m_next));
    check("s4_frame_addr", 32'(frame_addr), 32'(m_frame));
`ifdef ADC_FRAME_ERR_EN
    check("s4_err_pulse", err_pulses, 1);
    check("s4_err_count", 32'(err_count), 1);
`endif
    full_frame("s4", 3'd4, 1'b1);
    end_frame();

    // Reset mid-frame with cs_n still low
    run_frame(3'd6, 6, 1'b1, w);
    rst = 1'b1;
    @(negedge clk_50);
    rst = 1'b0;
    m_next = 3'd0; m_frame = 3'd0;
    d0 = done_cnt;
    run_frame(3'd6, 10, 1'b0, w);
    check("s5_dout_quiet", 32'(w[9:0]), 0);
    check("s5_no_done", done_cnt - d0, 0);
    check("s5_next_addr", 32'(next_addr), 0);
    end_frame();
    full_frame("s5", 3'd2, 1'b1);
    end_frame();

    // Master-style channel sweep
    ch_m[5] = 12'h123; ch_m[6] = 12'h456; ch_m[7] = 12'h789; pack_ch();
    full_frame("s6_a5", 3'd5, 1'b1);
    full_frame("s6_a6", 3'd6, 1'b0);
    full_frame("s6_a7", 3'd7, 1'b0);
    full_frame("s6_a0", 3'd0, 1'b0);
    end_frame();
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
